// File: rtl/rc_pkg.sv
// Shared definitions for the redundancy pair scheduler: scheduler state
// encoding and default lane/index geometry.
package rc_pkg;

    localparam logic [1:0] RC_ST_IDLE = 2'd0;
    localparam logic [1:0] RC_ST_RDY  = 2'd1;
    localparam logic [1:0] RC_ST_SCAN = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = RC_ST_IDLE,
        ST_RDY  = RC_ST_RDY,
        ST_SCAN = RC_ST_SCAN
    } rc_state_e;

    localparam int RC_ITER_WIDTH = 9;
    localparam int RC_STEP_RANGE = 128;

endpackage

// File: rtl/rc_index_fifo.sv
// Circular index buffer with push/pop, occupancy count and combinational head.
// A push and a pop in the same cycle leave the count unchanged.
module rc_index_fifo #(
    parameter int DATA_WIDTH = 9,
    parameter int DEPTH      = 128,
    parameter int PTR_WIDTH  = $clog2(DEPTH),
    parameter int CNT_WIDTH  = PTR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  can_accept
);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_WIDTH-1:0]  w_ptr_r;
    logic [PTR_WIDTH-1:0]  r_ptr_r;
    logic [CNT_WIDTH-1:0]  count_r;

    // Storage carries no reset; pointers and count alone define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[w_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            w_ptr_r <= {PTR_WIDTH{1'b0}};
            r_ptr_r <= {PTR_WIDTH{1'b0}};
            count_r <= {CNT_WIDTH{1'b0}};
        end else begin
            if (push) begin
                w_ptr_r <= w_ptr_r + PTR_WIDTH'(1);
            end
            if (pop) begin
                r_ptr_r <= r_ptr_r + PTR_WIDTH'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_WIDTH'(1);
                2'b01:   count_r <= count_r - CNT_WIDTH'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head       = mem_r[r_ptr_r];
    assign count      = count_r;
    assign can_accept = (count_r < CNT_WIDTH'(DEPTH)) || pop;

endmodule

// File: rtl/redundancy_pair_scheduler.sv
// Drains FL/NR lane bitmaps lowest-lane-first into two index buffers and emits
// (NR head, FL head) pairs. Optional occupancy ports: define RC_OCCUPANCY_EN.
module redundancy_pair_scheduler
    import rc_pkg::*;
#(
    parameter int ITER_WIDTH   = RC_ITER_WIDTH,
    parameter int STEP_RANGE   = RC_STEP_RANGE,
    parameter int FL_DEPTH     = 128,
    parameter int PTR_WIDTH    = $clog2(FL_DEPTH),
    parameter int NR_COL_LIMIT = 2,
    parameter int CNT_WIDTH    = PTR_WIDTH + 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable_in,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [STEP_RANGE-1:0]          fl_enable_ch,
    input  logic [STEP_RANGE*ITER_WIDTH-1:0] fl_it_in,
    input  logic [STEP_RANGE-1:0]          nr_enable_ch,
    input  logic [STEP_RANGE*ITER_WIDTH-1:0] nr_it_in,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ITER_WIDTH-1:0]          src_it,
    output logic [ITER_WIDTH-1:0]          dest_it,
    output logic                           busy
`ifdef RC_OCCUPANCY_EN
    ,
    output logic [CNT_WIDTH-1:0]           fl_count,
    output logic [CNT_WIDTH-1:0]           nr_count,
    output logic                           unpaired_drop
`endif
);

    localparam int VEC_WIDTH = STEP_RANGE * ITER_WIDTH;

    function automatic logic [ITER_WIDTH-1:0] lowest_index(
        input logic [STEP_RANGE-1:0] mask,
        input logic [VEC_WIDTH-1:0]  it_vec
    );
        logic [ITER_WIDTH-1:0] sel;
        sel = {ITER_WIDTH{1'b0}};
        for (int i = STEP_RANGE - 1; i >= 0; i--) begin
            sel = mask[i] ? it_vec[i*ITER_WIDTH +: ITER_WIDTH] : sel;
        end
        return sel;
    endfunction

    rc_state_e             state_r, state_nxt_s;
    logic [STEP_RANGE-1:0] fl_mask_r, nr_mask_r;
    logic [VEC_WIDTH-1:0]  fl_it_r, nr_it_r;
    logic [1:0]            batch_cnt_r;
    logic [CNT_WIDTH-1:0]  fl_count_s, nr_count_s;
    logic [ITER_WIDTH-1:0] fl_head_s, nr_head_s;
    logic                  fl_can_s, nr_can_s, fl_push_s, nr_push_s;
    logic                  flush_s, accept_s, nr_gate_s, pop_s, valid_s;

    assign flush_s   = (state_r == ST_IDLE);
    assign accept_s  = (state_r == ST_RDY) && in_valid;
    assign nr_gate_s = ({30'd0, batch_cnt_r} < NR_COL_LIMIT);
    assign fl_push_s = (state_r == ST_SCAN) && (|fl_mask_r) && fl_can_s;
    assign nr_push_s = (state_r == ST_SCAN) && (|nr_mask_r) && nr_can_s;
    assign valid_s   = (fl_count_s != {CNT_WIDTH{1'b0}}) && (nr_count_s != {CNT_WIDTH{1'b0}})
                       && (state_r != ST_IDLE);
    assign pop_s     = valid_s && out_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and handshake decode; a dropped enable always returns to IDLE.
    always_comb begin
        state_nxt_s = state_r;
        in_ready    = 1'b0;
        busy        = 1'b0;
        case (state_r)
            ST_IDLE: state_nxt_s = ST_RDY;
            ST_RDY: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt_s = ST_SCAN;
                end else begin
                    state_nxt_s = ST_RDY;
                end
            end
            ST_SCAN: begin
                busy = 1'b1;
                if ((fl_mask_r == {STEP_RANGE{1'b0}}) && (nr_mask_r == {STEP_RANGE{1'b0}})) begin
                    state_nxt_s = ST_RDY;
                end else begin
                    state_nxt_s = ST_SCAN;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
        if (!enable_in) begin
            state_nxt_s = ST_IDLE;
        end else begin
            state_nxt_s = state_nxt_s;
        end
    end

    // Batch capture and lane draining; x & (x-1) retires the lowest set lane.
    always_ff @(posedge clk) begin
        if (reset || flush_s) begin
            fl_mask_r   <= {STEP_RANGE{1'b0}};
            nr_mask_r   <= {STEP_RANGE{1'b0}};
            fl_it_r     <= {VEC_WIDTH{1'b0}};
            nr_it_r     <= {VEC_WIDTH{1'b0}};
            batch_cnt_r <= 2'd0;
        end else if (accept_s) begin
            fl_mask_r   <= fl_enable_ch;
            nr_mask_r   <= nr_gate_s ? nr_enable_ch : {STEP_RANGE{1'b0}};
            fl_it_r     <= fl_it_in;
            nr_it_r     <= nr_it_in;
            batch_cnt_r <= (batch_cnt_r == 2'd3) ? 2'd3 : batch_cnt_r + 2'd1;
        end else begin
            if (fl_push_s) begin
                fl_mask_r <= fl_mask_r & (fl_mask_r - STEP_RANGE'(1));
            end
            if (nr_push_s) begin
                nr_mask_r <= nr_mask_r & (nr_mask_r - STEP_RANGE'(1));
            end
        end
    end

    rc_index_fifo #(
        .DATA_WIDTH(ITER_WIDTH), .DEPTH(FL_DEPTH), .PTR_WIDTH(PTR_WIDTH), .CNT_WIDTH(CNT_WIDTH)
    ) u_fl_fifo (
        .clk(clk), .reset(reset), .flush(flush_s),
        .push(fl_push_s), .push_data(lowest_index(fl_mask_r, fl_it_r)), .pop(pop_s),
        .head(fl_head_s), .count(fl_count_s), .can_accept(fl_can_s)
    );

    rc_index_fifo #(
        .DATA_WIDTH(ITER_WIDTH), .DEPTH(FL_DEPTH), .PTR_WIDTH(PTR_WIDTH), .CNT_WIDTH(CNT_WIDTH)
    ) u_nr_fifo (
        .clk(clk), .reset(reset), .flush(flush_s),
        .push(nr_push_s), .push_data(lowest_index(nr_mask_r, nr_it_r)), .pop(pop_s),
        .head(nr_head_s), .count(nr_count_s), .can_accept(nr_can_s)
    );

    assign out_valid = valid_s;
    assign src_it    = valid_s ? nr_head_s : {ITER_WIDTH{1'b0}};
    assign dest_it   = valid_s ? fl_head_s : {ITER_WIDTH{1'b0}};

`ifdef RC_OCCUPANCY_EN
    logic drop_r;

    // Sticky record of buffered entries discarded by an IDLE flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_r <= 1'b0;
        end else if (flush_s && ((fl_count_s != {CNT_WIDTH{1'b0}}) || (nr_count_s != {CNT_WIDTH{1'b0}}))) begin
            drop_r <= 1'b1;
        end else begin
            drop_r <= drop_r;
        end
    end

    assign fl_count      = fl_count_s;
    assign nr_count      = nr_count_s;
    assign unpaired_drop = drop_r;
`endif

endmodule

// File: tb/tb_redundancy_pair_scheduler.sv
// Directed + randomized bench for redundancy_pair_scheduler against a queue-based
// reference model of batches, pending lanes and the two index buffers.
module tb_redundancy_pair_scheduler;

    localparam int IW    = 9;
    localparam int SR    = 8;
    localparam int DEPTH = 4;
    localparam int LIMIT = 2;
    localparam int CW    = 3;
    localparam int M_IDLE = 0, M_RDY = 1, M_SCAN = 2;

    logic             clk;
    logic             reset, enable_in, in_valid, in_ready, out_valid, out_ready, busy;
    logic [SR-1:0]    fl_enable_ch, nr_enable_ch;
    logic [SR*IW-1:0] fl_it_in, nr_it_in;
    logic [IW-1:0]    src_it, dest_it;
`ifdef RC_OCCUPANCY_EN
    logic [CW-1:0]    fl_count, nr_count;
    logic             unpaired_drop;
`endif

    redundancy_pair_scheduler #(
        .ITER_WIDTH(IW), .STEP_RANGE(SR), .FL_DEPTH(DEPTH), .NR_COL_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .reset(reset), .enable_in(enable_in),
        .in_valid(in_valid), .in_ready(in_ready),
        .fl_enable_ch(fl_enable_ch), .fl_it_in(fl_it_in),
        .nr_enable_ch(nr_enable_ch), .nr_it_in(nr_it_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .src_it(src_it), .dest_it(dest_it), .busy(busy)
`ifdef RC_OCCUPANCY_EN
        , .fl_count(fl_count), .nr_count(nr_count), .unpaired_drop(unpaired_drop)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model
    int m_phase;
    int m_batches;
    bit m_drop;
    int fl_q[$], nr_q[$], fl_pend[$], nr_pend[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        fl_q.delete(); nr_q.delete(); fl_pend.delete(); nr_pend.delete();
        m_batches = 0;
    endtask

    task automatic compare_outputs();
        logic ev;
        ev = (fl_q.size() > 0) && (nr_q.size() > 0) && (m_phase != M_IDLE);
        check("in_ready", {31'd0, in_ready}, {31'd0, m_phase == M_RDY});
        check("busy", {31'd0, busy}, {31'd0, m_phase == M_SCAN});
        check("out_valid", {31'd0, out_valid}, {31'd0, ev});
        check("src_it", {23'd0, src_it}, ev ? 32'(nr_q[0]) : 32'd0);
        check("dest_it", {23'd0, dest_it}, ev ? 32'(fl_q[0]) : 32'd0);
`ifdef RC_OCCUPANCY_EN
        check("fl_count", {29'd0, fl_count}, 32'(fl_q.size()));
        check("nr_count", {29'd0, nr_count}, 32'(nr_q.size()));
        check("unpaired_drop", {31'd0, unpaired_drop}, {31'd0, m_drop});
`endif
    endtask

    task automatic model_step();
        bit ev, pop, fpush, npush, pend_empty;
        int nphase;
        if (reset) begin
            model_clear();
            m_drop  = 1'b0;
            m_phase = M_IDLE;
            return;
        end
        ev = (fl_q.size() > 0) && (nr_q.size() > 0) && (m_phase != M_IDLE);
        pop = ev && out_ready;
        pend_empty = (fl_pend.size() == 0) && (nr_pend.size() == 0);
        fpush = (m_phase == M_SCAN) && (fl_pend.size() > 0) && ((fl_q.size() < DEPTH) || pop);
        npush = (m_phase == M_SCAN) && (nr_pend.size() > 0) && ((nr_q.size() < DEPTH) || pop);
        if (pop) begin
            void'(fl_q.pop_front());
            void'(nr_q.pop_front());
        end
        if (fpush) fl_q.push_back(fl_pend.pop_front());
        if (npush) nr_q.push_back(nr_pend.pop_front());
        nphase = m_phase;
        if (m_phase == M_IDLE) begin
            if (fl_q.size() > 0 || nr_q.size() > 0) m_drop = 1'b1;
            model_clear();
            nphase = M_RDY;
        end else if (m_phase == M_RDY) begin
            if (in_valid) begin
                for (int i = 0; i < SR; i++) begin
                    if (fl_enable_ch[i]) fl_pend.push_back(int'(fl_it_in[i*IW +: IW]));
                    if (nr_enable_ch[i] && m_batches < LIMIT) nr_pend.push_back(int'(nr_it_in[i*IW +: IW]));
                end
                if (m_batches < 3) m_batches++;
                nphase = M_SCAN;
            end
        end else if (pend_empty) begin
            nphase = M_RDY;
        end
        if (!enable_in) nphase = M_IDLE;
        m_phase = nphase;
    endtask

    task automatic cycle();
        @(negedge clk);
        compare_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic load_batch(input logic [SR-1:0] fm, input logic [SR-1:0] nm);
        fl_enable_ch = fm;
        nr_enable_ch = nm;
        for (int i = 0; i < SR; i++) begin
            fl_it_in[i*IW +: IW] = IW'($urandom_range(0, 511));
            nr_it_in[i*IW +: IW] = IW'($urandom_range(0, 511));
        end
    endtask

    task automatic send_batch();
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 40) begin
            cycle();
            n++;
        end
        check("rdy_wait", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic bounce_enable();
        enable_in = 1'b0;
        cycle();
        enable_in = 1'b1;
        cycle();
    endtask

    initial begin
        reset = 1'b1; enable_in = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        fl_enable_ch = '0; nr_enable_ch = '0; fl_it_in = '0; nr_it_in = '0;
        @(posedge clk);
        #1;
        model_clear();
        m_drop = 1'b0;
        m_phase = M_IDLE;
        run(2);
        reset = 1'b0;
        cycle();

        // basic pairing
        out_ready = 1'b1;
        load_batch(8'b0000_1010, 8'b0000_0011);
        fl_it_in[1*IW +: IW] = 9'd5;
        fl_it_in[3*IW +: IW] = 9'd7;
        nr_it_in[0*IW +: IW] = 9'd2;
        nr_it_in[1*IW +: IW] = 9'd9;
        send_batch();
        cycle();
        check("pair1_valid", {31'd0, out_valid}, 32'd1);
        check("pair1_src", {23'd0, src_it}, 32'd2);
        check("pair1_dest", {23'd0, dest_it}, 32'd5);
        cycle();
        check("pair2_src", {23'd0, src_it}, 32'd9);
        check("pair2_dest", {23'd0, dest_it}, 32'd7);
        cycle();
        check("basic_done_valid", {31'd0, out_valid}, 32'd0);
        check("basic_done_rdy", {31'd0, in_ready}, 32'd1);

        // batch counter gate
        bounce_enable();
        for (int b = 0; b < 3; b++) begin
            load_batch(8'b1, 8'b1);
            fl_it_in[0 +: IW] = 9'd6;
            nr_it_in[0 +: IW] = 9'd4;
            send_batch();
            run(3);
        end
        check("gate_unpaired_valid", {31'd0, out_valid}, 32'd0);
`ifdef RC_OCCUPANCY_EN
        check("gate_fl_count", {29'd0, fl_count}, 32'd1);
`endif

        // backpressure with full buffers and pointer wrap
        bounce_enable();
        out_ready = 1'b0;
        load_batch(8'b0011_1111, 8'b0011_1111);
        send_batch();
        run(8);
        check("full_scan_holds", {31'd0, busy}, 32'd1);
        out_ready = 1'b1;
        run(10);
        check("full_drained", {31'd0, out_valid}, 32'd0);
        check("full_rdy", {31'd0, in_ready}, 32'd1);

        // empty batch
        load_batch(8'b0, 8'b0);
        send_batch();
        check("empty_scan", {31'd0, busy}, 32'd1);
        cycle();
        check("empty_back_rdy", {31'd0, in_ready}, 32'd1);

        // flush mid-scan with buffered pairs
        bounce_enable();
        out_ready = 1'b0;
        load_batch(8'b0011_1111, 8'b0000_0111);
        send_batch();
        run(3);
        enable_in = 1'b0;
        cycle();
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        enable_in = 1'b1;
        run(2);

        // reset mid-scan
        load_batch(8'hFF, 8'hFF);
        send_batch();
        cycle();
        reset = 1'b1;
        cycle();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_src", {23'd0, src_it}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd0);
        reset = 1'b0;
        cycle();
        check("rst_then_rdy", {31'd0, in_ready}, 32'd1);

        // randomized traffic
        for (int r = 0; r < 600; r++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 3) != 0);
            enable_in = ($urandom_range(0, 39) != 0);
            reset     = ($urandom_range(0, 99) == 0);
            if (in_ready === 1'b1) begin
                load_batch(($urandom_range(0, 3) == 0) ? 8'h00 : SR'($urandom),
                           ($urandom_range(0, 3) == 0) ? 8'h00 : SR'($urandom));
            end
            cycle();
        end
        in_valid = 1'b0;
        reset = 1'b0;
        enable_in = 1'b1;
        out_ready = 1'b1;
        run(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
